// File: rtl/noc_pkg.sv
// Shared types for the mesh injector slice.
// Mesh geometry, packet header layout and injector FSM states.
package noc_pkg;

  localparam int MESH_SIDE = 4;
  localparam int CW = $clog2(MESH_SIDE);

  typedef logic [CW-1:0] coord_t;

  typedef struct packed {
    logic   s_delta_x;
    logic   s_delta_y;
    coord_t dest_x;
    coord_t dest_y;
  } pkt_hdr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } inj_state_e;

  function automatic logic coord_ok(coord_t c);
    return int'(c) < MESH_SIDE;
  endfunction

endpackage

// File: rtl/noc_pkt_fifo.sv
// Synchronous packet FIFO, header plus payload per entry.
// Pointers carry one extra wrap bit to tell full from empty.
module noc_pkt_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;

  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = (wp == rp);
  assign rdata = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full)
        wp <= wp + 1'b1;
      if (pop && !empty)
        rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/noc_injector.sv
// Local packet source for one mesh node: PE valid/ready in,
// buffered, delivered to the router over a 4-phase req/ack.
module noc_injector
  import noc_pkg::*;
#(
  parameter int X_COORD    = 0,
  parameter int Y_COORD    = 0,
  parameter int DATA_W     = 512,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  coord_t            in_dest_x,
  input  coord_t            in_dest_y,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_err,
  output logic              req,
  input  logic              ack,
  output logic [DATA_W-1:0] data,
  output logic              s_delta_x,
  output logic              s_delta_y,
  output coord_t            dest_x,
  output coord_t            dest_y,
  output logic [15:0]       sent_cnt
);

  localparam int HW = $bits(pkt_hdr_t);

  pkt_hdr_t          in_hdr;
  pkt_hdr_t          head_hdr;
  logic [DATA_W-1:0] head_data;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              bad_dest;
  logic              is_self;
  inj_state_e        state;
  inj_state_e        state_n;
  logic [15:0]       sent_cnt_n;

  assign in_ready = !full;

  always_comb begin
    is_self  = (in_dest_x == coord_t'(X_COORD)) &&
               (in_dest_y == coord_t'(Y_COORD));
    bad_dest = is_self ||
               !coord_ok(in_dest_x) ||
               !coord_ok(in_dest_y);
    push     = in_valid && in_ready && !bad_dest;
    in_hdr.s_delta_x = in_dest_x < coord_t'(X_COORD);
    in_hdr.s_delta_y = in_dest_y < coord_t'(Y_COORD);
    in_hdr.dest_x    = in_dest_x;
    in_hdr.dest_y    = in_dest_y;
  end

  noc_pkt_fifo #(
    .W     (HW + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({in_hdr, in_data}),
    .pop   (pop),
    .rdata ({head_hdr, head_data}),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_n    = state;
    pop        = 1'b0;
    sent_cnt_n = sent_cnt;
    unique case (state)
      IDLE: begin
        if (!empty && !ack) begin
          pop     = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        if (ack)
          state_n = REL;
      end
      REL: begin
        if (!ack) begin
          state_n    = IDLE;
          sent_cnt_n = sent_cnt + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs only move on a pop, so they hold from req rise to ack fall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req       <= 1'b0;
      in_err    <= 1'b0;
      sent_cnt  <= '0;
      data      <= '0;
      s_delta_x <= 1'b0;
      s_delta_y <= 1'b0;
      dest_x    <= '0;
      dest_y    <= '0;
    end else begin
      state    <= state_n;
      req      <= (state_n == REQ);
      in_err   <= in_valid && in_ready && bad_dest;
      sent_cnt <= sent_cnt_n;
      if (pop) begin
        data      <= head_data;
        s_delta_x <= head_hdr.s_delta_x;
        s_delta_y <= head_hdr.s_delta_y;
        dest_x    <= head_hdr.dest_x;
        dest_y    <= head_hdr.dest_y;
      end
    end
  end

endmodule

// File: tb/tb_noc_injector.sv
// Directed bench for noc_injector at node (1,2) of a 4x4 mesh.
// Vector table for header/reject cases plus multi-cycle sequences.
module tb_noc_injector;
  import noc_pkg::*;

  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  coord_t        in_dest_x = '0;
  coord_t        in_dest_y = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_err;
  logic          req;
  logic          ack = 1'b0;
  logic [DW-1:0] data;
  logic          s_delta_x;
  logic          s_delta_y;
  coord_t        dest_x;
  coord_t        dest_y;
  logic [15:0]   sent_cnt;

  logic          auto_ack = 1'b0;
  int            total = 0;
  int            bad = 0;
  logic [15:0]   exp_cnt = '0;

  noc_injector #(
    .X_COORD    (1),
    .Y_COORD    (2),
    .DATA_W     (DW),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dest_x (in_dest_x),
    .in_dest_y (in_dest_y),
    .in_data   (in_data),
    .in_err    (in_err),
    .req       (req),
    .ack       (ack),
    .data      (data),
    .s_delta_x (s_delta_x),
    .s_delta_y (s_delta_y),
    .dest_x    (dest_x),
    .dest_y    (dest_y),
    .sent_cnt  (sent_cnt)
  );

  always #5 clk = ~clk;

  // Router model: ack mirrors req one cycle later
  initial begin
    forever begin
      @(negedge clk);
      if (auto_ack)
        ack = req;
    end
  end

  typedef struct {
    int   dx;
    int   dy;
    logic err;
    logic sdx;
    logic sdy;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(string nm, logic [DW-1:0] act,
                     logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_req(string nm);
    int n = 0;
    while (req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(nm, DW'(req), DW'(1));
  endtask

  function automatic logic [DW-1:0] pat(int i);
    logic [31:0] w;
    w = 32'hC0DE0000 + 32'(i);
    return {16{w}};
  endfunction

  logic [DW-1:0] vd;

  initial begin
    vecs[0] = '{3, 0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1, 2, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{0, 3, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1, 0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{0, 2, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{2, 2, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1, 3, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{0, 0, 1'b0, 1'b1, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_req", DW'(req), DW'(0));
    chk("rst_cnt", DW'(sent_cnt), DW'(0));
    chk("rst_data", data, '0);
    chk("rst_err", DW'(in_err), DW'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", DW'(in_ready), DW'(1));

    // Table: header bits, reject pulse, latency, count
    auto_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vd = (i == 0) ? {64{8'hA5}} : pat(i);
      in_valid  = 1'b1;
      in_dest_x = coord_t'(vecs[i].dx);
      in_dest_y = coord_t'(vecs[i].dy);
      in_data   = vd;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_err", i), DW'(in_err), DW'(vecs[i].err));
      chk($sformatf("v%0d_req0", i), DW'(req), DW'(0));
      @(negedge clk);
      if (vecs[i].err) begin
        chk($sformatf("v%0d_errpulse", i), DW'(in_err), DW'(0));
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_noreq", i), DW'(req), DW'(0));
      end else begin
        chk($sformatf("v%0d_req1", i), DW'(req), DW'(1));
        chk($sformatf("v%0d_sdx", i), DW'(s_delta_x), DW'(vecs[i].sdx));
        chk($sformatf("v%0d_sdy", i), DW'(s_delta_y), DW'(vecs[i].sdy));
        chk($sformatf("v%0d_dx", i), DW'(dest_x), DW'(vecs[i].dx));
        chk($sformatf("v%0d_dy", i), DW'(dest_y), DW'(vecs[i].dy));
        chk($sformatf("v%0d_data", i), data, vd);
        repeat (2) @(negedge clk);
        exp_cnt++;
        chk($sformatf("v%0d_reqoff", i), DW'(req), DW'(0));
      end
      chk($sformatf("v%0d_cnt", i), DW'(sent_cnt), DW'(exp_cnt));
    end
    auto_ack = 1'b0;
    ack = 1'b0;
    @(negedge clk);

    // Stall router, fill output reg plus four FIFO entries
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("fill%0d_ready", i), DW'(in_ready), DW'(1));
      in_valid  = 1'b1;
      in_dest_x = coord_t'(i % 4);
      in_dest_y = '0;
      in_data   = pat(100 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("full_ready", DW'(in_ready), DW'(0));
    repeat (3) @(negedge clk);
    chk("full_hold", DW'(in_ready), DW'(0));
    for (int i = 0; i < 5; i++) begin
      wait_req($sformatf("drain%0d_req", i));
      chk($sformatf("drain%0d_data", i), data, pat(100 + i));
      chk($sformatf("drain%0d_dx", i), DW'(dest_x), DW'(i % 4));
      chk($sformatf("drain%0d_sdy", i), DW'(s_delta_y), DW'(1));
      ack = 1'b1;
      @(negedge clk);
      chk($sformatf("drain%0d_rel", i), DW'(req), DW'(0));
      chk($sformatf("drain%0d_stab1", i), data, pat(100 + i));
      ack = 1'b0;
      @(negedge clk);
      chk($sformatf("drain%0d_stab2", i), data, pat(100 + i));
      chk($sformatf("drain%0d_dxs", i), DW'(dest_x), DW'(i % 4));
      exp_cnt++;
      chk($sformatf("drain%0d_cnt", i), DW'(sent_cnt), DW'(exp_cnt));
    end
    chk("drained_ready", DW'(in_ready), DW'(1));

    // Async reset in the middle of a handshake
    in_valid  = 1'b1;
    in_dest_x = 2'd3;
    in_dest_y = 2'd3;
    in_data   = pat(200);
    @(negedge clk);
    in_data = pat(201);
    @(negedge clk);
    in_valid = 1'b0;
    wait_req("mrst_req");
    #2 rst = 1'b0;
    #1;
    chk("mrst_req_async", DW'(req), DW'(0));
    chk("mrst_cnt", DW'(sent_cnt), DW'(0));
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_ready", DW'(in_ready), DW'(1));
    repeat (3) @(negedge clk);
    chk("mrst_empty", DW'(req), DW'(0));
    chk("mrst_data", data, '0);

    // ack high while IDLE must hold off the next request
    ack = 1'b1;
    in_valid  = 1'b1;
    in_dest_x = 2'd2;
    in_dest_y = 2'd1;
    in_data   = pat(300);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("ackidle_hold", DW'(req), DW'(0));
    ack = 1'b0;
    @(negedge clk);
    chk("ackidle_req", DW'(req), DW'(1));
    chk("ackidle_data", data, pat(300));
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    exp_cnt++;
    chk("ackidle_cnt", DW'(sent_cnt), DW'(exp_cnt));

    // Counter wrap from 0xFFFF
    force dut.sent_cnt = 16'hFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    release dut.sent_cnt;
    @(negedge clk);
    chk("wrap_pre", DW'(sent_cnt), DW'(16'hFFFF));
    auto_ack  = 1'b1;
    in_valid  = 1'b1;
    in_dest_x = 2'd0;
    in_dest_y = 2'd1;
    in_data   = pat(400);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("wrap_cnt", DW'(sent_cnt), DW'(0));
    auto_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
